// File: rtl/risc_ctrl_pkg.sv
// Shared control constants for the branch/hazard logic: opcodes, register index width, FSM states.
package risc_ctrl_pkg;

    localparam logic [3:0] OP_JMP = 4'b0001;
    localparam logic [3:0] OP_BEQ = 4'b0010;
    localparam logic [3:0] OP_BGT = 4'b0011;
    localparam logic [3:0] OP_BLE = 4'b0100;
    localparam logic [3:0] OP_LW  = 4'b0101;
    localparam logic [3:0] OP_SW  = 4'b0110;

    localparam int REG_IDX_W = 4;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } bhu_state_t;

endpackage

// File: rtl/branch_hazard_unit_br_compare.sv
// Signed branch condition evaluation; several enabled flags combine by OR.
module br_compare #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              gt_bra,
    input  logic              le_bra,
    input  logic              eq_bra,
    output logic              taken
);

    logic a_gt_b;
    logic a_eq_b;

    assign a_gt_b = $signed(a) > $signed(b);
    assign a_eq_b = (a == b);
    assign taken  = (gt_bra & a_gt_b) | (le_bra & ~a_gt_b) | (eq_bra & a_eq_b);

endmodule

// File: rtl/branch_hazard_unit.sv
// Jump/branch redirect and load-use stall control for the pipeline flush interface.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_hazard_unit
    import risc_ctrl_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 16,
    parameter int LU_STALL_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_jump,
    input  logic [ADDR_W-1:0]    id_jump_tgt,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 ex_gt_bra,
    input  logic                 ex_le_bra,
    input  logic                 ex_eq_bra,
    input  logic [DATA_W-1:0]    ex_a,
    input  logic [DATA_W-1:0]    ex_b,
    input  logic [ADDR_W-1:0]    ex_br_tgt,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    output logic                 pcsrc1,
    output logic                 pcsrc2,
    output logic                 pc_sel,
    output logic [ADDR_W-1:0]    pc_target,
    output logic                 pc_stall,
    output logic                 bubble
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]          stat_taken,
    output logic [15:0]          stat_stall
`endif
);

    localparam logic [1:0] STALL_INIT = 2'(LU_STALL_CYC - 1);

    bhu_state_t state;
    bhu_state_t next_state;
    logic [1:0] cnt;
    logic [1:0] next_cnt;
    logic       br_taken;
    logic       hazard;

    br_compare #(.DATA_W(DATA_W)) u_cmp (
        .a      (ex_a),
        .b      (ex_b),
        .gt_bra (ex_gt_bra),
        .le_bra (ex_le_bra),
        .eq_bra (ex_eq_bra),
        .taken  (br_taken)
    );

    assign hazard = ex_mem_read & (ex_rd != '0) & ((ex_rd == id_rs) | (ex_rd == id_rt));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // A taken branch flushes the stalled instruction, so it always wins over the stall.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            RUN: begin
                if (hazard && !br_taken && (LU_STALL_CYC > 1)) begin
                    next_state = STALL;
                    next_cnt   = STALL_INIT;
                end
            end
            STALL: begin
                if (br_taken || cnt <= 2'd1) begin
                    next_state = RUN;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt - 2'd1;
                end
            end
            default: begin
                next_state = RUN;
                next_cnt   = '0;
            end
        endcase
    end

    // Outputs are forced low while reset is asserted.
    always_comb begin
        pcsrc1    = 1'b0;
        pcsrc2    = 1'b0;
        pc_stall  = 1'b0;
        bubble    = 1'b0;
        pc_sel    = 1'b0;
        pc_target = '0;
        if (rst_n) begin
            pcsrc2   = br_taken;
            pc_stall = ~br_taken & ((state == STALL) | hazard);
            bubble   = pc_stall;
            pcsrc1   = id_jump & ~br_taken & ~hazard & (state == RUN);
            pc_sel   = pcsrc1 | pcsrc2;
            if (pcsrc2) begin
                pc_target = ex_br_tgt;
            end else if (pcsrc1) begin
                pc_target = id_jump_tgt;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_taken <= '0;
            stat_stall <= '0;
        end else begin
            if (pcsrc2 && stat_taken != 16'hFFFF) begin
                stat_taken <= stat_taken + 16'd1;
            end
            if (pc_stall && stat_stall != 16'hFFFF) begin
                stat_stall <= stat_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Bench for branch_hazard_unit: two instances (1- and 3-cycle load-use stall) share stimulus
// and are checked every cycle against a remaining-stall-cycles model plus directed literals.
module tb_branch_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_jump;
    logic [15:0] id_jump_tgt;
    logic [3:0]  id_rs, id_rt;
    logic        ex_gt_bra, ex_le_bra, ex_eq_bra;
    logic [15:0] ex_a, ex_b, ex_br_tgt;
    logic        ex_mem_read;
    logic [3:0]  ex_rd;

    logic        a_pcsrc1, a_pcsrc2, a_pc_sel, a_pc_stall, a_bubble;
    logic [15:0] a_pc_target;
    logic        b_pcsrc1, b_pcsrc2, b_pc_sel, b_pc_stall, b_bubble;
    logic [15:0] b_pc_target;
`ifdef BRANCH_STATS_EN
    logic [15:0] a_stat_taken, a_stat_stall, b_stat_taken, b_stat_stall;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;
    bit started      = 1'b0;

    typedef struct packed {
        logic        pcsrc1;
        logic        pcsrc2;
        logic        pc_sel;
        logic [15:0] pc_target;
        logic        pc_stall;
        logic        bubble;
    } exp_t;

    int stall_left_a = 0, stall_left_b = 0;
    int taken_cnt_a = 0, stall_cnt_a = 0, taken_cnt_b = 0, stall_cnt_b = 0;

    always #5 clk = ~clk;

    branch_hazard_unit #(.DATA_W(16), .ADDR_W(16), .LU_STALL_CYC(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_jump(id_jump), .id_jump_tgt(id_jump_tgt),
        .id_rs(id_rs), .id_rt(id_rt), .ex_gt_bra(ex_gt_bra), .ex_le_bra(ex_le_bra),
        .ex_eq_bra(ex_eq_bra), .ex_a(ex_a), .ex_b(ex_b), .ex_br_tgt(ex_br_tgt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .pcsrc1(a_pcsrc1), .pcsrc2(a_pcsrc2), .pc_sel(a_pc_sel), .pc_target(a_pc_target),
        .pc_stall(a_pc_stall), .bubble(a_bubble)
`ifdef BRANCH_STATS_EN
        , .stat_taken(a_stat_taken), .stat_stall(a_stat_stall)
`endif
    );

    branch_hazard_unit #(.DATA_W(16), .ADDR_W(16), .LU_STALL_CYC(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_jump(id_jump), .id_jump_tgt(id_jump_tgt),
        .id_rs(id_rs), .id_rt(id_rt), .ex_gt_bra(ex_gt_bra), .ex_le_bra(ex_le_bra),
        .ex_eq_bra(ex_eq_bra), .ex_a(ex_a), .ex_b(ex_b), .ex_br_tgt(ex_br_tgt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .pcsrc1(b_pcsrc1), .pcsrc2(b_pcsrc2), .pc_sel(b_pc_sel), .pc_target(b_pc_target),
        .pc_stall(b_pc_stall), .bubble(b_bubble)
`ifdef BRANCH_STATS_EN
        , .stat_taken(b_stat_taken), .stat_stall(b_stat_stall)
`endif
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Outputs follow from the branch rules and the number of stall cycles still owed.
    function automatic exp_t model_out(input int stall_left);
        exp_t e;
        bit   taken, hazard;
        int   sa, sb;
        e = '0;
        sa = int'($signed(ex_a));
        sb = int'($signed(ex_b));
        taken  = (ex_gt_bra && sa > sb) || (ex_le_bra && sa <= sb) || (ex_eq_bra && sa == sb);
        hazard = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs || ex_rd == id_rt);
        if (!rst_n) begin
            e = '0;
        end else if (taken) begin
            e.pcsrc2 = 1'b1; e.pc_sel = 1'b1; e.pc_target = ex_br_tgt;
        end else if (stall_left > 0 || hazard) begin
            e.pc_stall = 1'b1; e.bubble = 1'b1;
        end else if (id_jump) begin
            e.pcsrc1 = 1'b1; e.pc_sel = 1'b1; e.pc_target = id_jump_tgt;
        end
        return e;
    endfunction

    function automatic int model_next(input int stall_left, input int len, input exp_t e);
        if (!rst_n || e.pcsrc2) return 0;
        if (stall_left > 0) return stall_left - 1;
        if (e.pc_stall) return len - 1;
        return 0;
    endfunction

    function automatic int sat_inc(input int v, input bit en);
        if (!rst_n) return 0;
        if (en && v < 65535) return v + 1;
        return v;
    endfunction

    always @(posedge clk) begin
        exp_t ea, eb;
        ea = model_out(stall_left_a);
        eb = model_out(stall_left_b);
        taken_cnt_a  = sat_inc(taken_cnt_a, ea.pcsrc2);
        stall_cnt_a  = sat_inc(stall_cnt_a, ea.pc_stall);
        taken_cnt_b  = sat_inc(taken_cnt_b, eb.pcsrc2);
        stall_cnt_b  = sat_inc(stall_cnt_b, eb.pc_stall);
        stall_left_a = model_next(stall_left_a, 1, ea);
        stall_left_b = model_next(stall_left_b, 3, eb);
    end

    always @(negedge clk) begin
        exp_t ea, eb;
        if (started) begin
            ea = model_out(stall_left_a);
            eb = model_out(stall_left_b);
            check_output("a_pcsrc1", a_pcsrc1, ea.pcsrc1);
            check_output("a_pcsrc2", a_pcsrc2, ea.pcsrc2);
            check_output("a_pc_sel", a_pc_sel, ea.pc_sel);
            check_output("a_pc_target", a_pc_target, ea.pc_target);
            check_output("a_pc_stall", a_pc_stall, ea.pc_stall);
            check_output("a_bubble", a_bubble, ea.bubble);
            check_output("b_pcsrc1", b_pcsrc1, eb.pcsrc1);
            check_output("b_pcsrc2", b_pcsrc2, eb.pcsrc2);
            check_output("b_pc_sel", b_pc_sel, eb.pc_sel);
            check_output("b_pc_target", b_pc_target, eb.pc_target);
            check_output("b_pc_stall", b_pc_stall, eb.pc_stall);
            check_output("b_bubble", b_bubble, eb.bubble);
`ifdef BRANCH_STATS_EN
            if (n_compared > 24) begin
                check_output("a_stat_taken", a_stat_taken, taken_cnt_a);
                check_output("a_stat_stall", a_stat_stall, stall_cnt_a);
                check_output("b_stat_taken", b_stat_taken, taken_cnt_b);
                check_output("b_stat_stall", b_stat_stall, stall_cnt_b);
            end
`endif
        end
    end

    task automatic apply_idle();
        id_jump = 0; id_jump_tgt = '0; id_rs = '0; id_rt = '0;
        ex_gt_bra = 0; ex_le_bra = 0; ex_eq_bra = 0;
        ex_a = '0; ex_b = '0; ex_br_tgt = '0; ex_mem_read = 0; ex_rd = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        apply_idle();
        rst_n = 1'b0;
        step();
        started = 1'b1;
        @(negedge clk);
        check_output("reset_pc_sel", a_pc_sel, 0);
        check_output("reset_pc_stall", b_pc_stall, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check_output("run_idle_target", a_pc_target, 0);

        // BEQ equal operands, same-cycle redirect
        ex_eq_bra = 1; ex_a = 16'd5; ex_b = 16'd5; ex_br_tgt = 16'h0040;
        @(negedge clk);
        check_output("beq_pcsrc2", a_pcsrc2, 1);
        check_output("beq_pc_sel", a_pc_sel, 1);
        check_output("beq_target", a_pc_target, 16'h0040);
        check_output("beq_pcsrc1", a_pcsrc1, 0);
        step();

        apply_idle(); ex_gt_bra = 1; ex_a = 16'hFFFF; ex_b = 16'd1; ex_br_tgt = 16'h0077;
        @(negedge clk);
        check_output("bgt_neg_pcsrc2", a_pcsrc2, 0);
        step();
        apply_idle(); ex_le_bra = 1; ex_a = 16'hFFFF; ex_b = 16'd1; ex_br_tgt = 16'h0078;
        @(negedge clk);
        check_output("ble_neg_pcsrc2", a_pcsrc2, 1);
        step();
        apply_idle(); ex_le_bra = 1; ex_a = 16'd7; ex_b = 16'd7;
        @(negedge clk);
        check_output("ble_equal_pcsrc2", a_pcsrc2, 1);
        step();
        apply_idle(); ex_gt_bra = 1; ex_a = 16'h7FFF; ex_b = 16'h8000;
        @(negedge clk);
        check_output("bgt_extreme_pcsrc2", a_pcsrc2, 1);
        step();

        // Load-use via rs, one-cycle stall on dut_a
        apply_idle(); ex_mem_read = 1; ex_rd = 4'd3; id_rs = 4'd3;
        @(negedge clk);
        check_output("lu_stall", a_pc_stall, 1);
        check_output("lu_bubble", a_bubble, 1);
        step();
        apply_idle();
        @(negedge clk);
        check_output("lu_release", a_pc_stall, 0);
        repeat (3) step();
        ex_mem_read = 1; ex_rd = 4'd0;
        @(negedge clk);
        check_output("r0_no_stall_a", a_pc_stall, 0);
        check_output("r0_no_stall_b", b_pc_stall, 0);
        step();
        apply_idle(); ex_mem_read = 1; ex_rd = 4'd5; id_rs = 4'd2; id_rt = 4'd5;
        @(negedge clk);
        check_output("lu_rt_stall", a_pc_stall, 1);
        step();
        apply_idle();
        repeat (3) step();

        // Jump and branch in the same cycle: branch wins
        id_jump = 1; id_jump_tgt = 16'h0010; ex_eq_bra = 1; ex_br_tgt = 16'h0020;
        @(negedge clk);
        check_output("prio_pcsrc2", a_pcsrc2, 1);
        check_output("prio_pcsrc1", a_pcsrc1, 0);
        check_output("prio_target", a_pc_target, 16'h0020);
        step();

        // Hazard cancelled by taken branch
        apply_idle(); ex_mem_read = 1; ex_rd = 4'd4; id_rs = 4'd4; ex_eq_bra = 1; ex_br_tgt = 16'h0030;
        @(negedge clk);
        check_output("cancel_stall", b_pc_stall, 0);
        check_output("cancel_pcsrc2", b_pcsrc2, 1);
        step();
        apply_idle();
        @(negedge clk);
        check_output("cancel_stays_run", b_pc_stall, 0);
        step();

        // Three-cycle stall with a jump waiting in ID
        id_jump = 1; id_jump_tgt = 16'h0055; ex_mem_read = 1; ex_rd = 4'd6; id_rs = 4'd6;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("lu3_stall", b_pc_stall, 1);
            check_output("lu3_no_jump", b_pcsrc1, 0);
            step();
            ex_mem_read = 0;
        end
        @(negedge clk);
        check_output("lu3_jump_fires", b_pcsrc1, 1);
        check_output("lu3_jump_target", b_pc_target, 16'h0055);
        check_output("lu3_released", b_pc_stall, 0);
        step();
        apply_idle();
        step();

        // Reset in the middle of a stall
        ex_mem_read = 1; ex_rd = 4'd7; id_rt = 4'd7;
        @(negedge clk);
        check_output("rst_pre_stall", b_pc_stall, 1);
        step();
        apply_idle(); rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check_output("rst_mid_stall", b_pc_stall, 0);
        check_output("rst_mid_bubble", b_bubble, 0);
        check_output("rst_mid_pc_sel", b_pc_sel, 0);
`ifdef BRANCH_STATS_EN
        check_output("rst_stat_taken", b_stat_taken, 0);
        check_output("rst_stat_stall", b_stat_stall, 0);
`endif
        repeat (2) step();

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
